// File: rtl/host_frame_sequencer.sv
// Host frame sequencer: scans a completed serializer frame, validates header,
// length and checksum, then streams the payload to the selected target.
module host_frame_sequencer #(
  parameter int NUM_TARGETS = 4,
  parameter int TGT_W       = 2
) (
  input  logic             inCLK,
  input  logic             inRST,
  input  logic             inFrameDone,
  input  logic [8:0]       inFrameLen,
  output logic [7:0]       byteAddr,
  input  logic [7:0]       inByte,
  output logic [7:0]       outData,
  output logic             outValid,
  input  logic             inReady,
  output logic             outLast,
  output logic [TGT_W-1:0] outTarget,
  output logic [7:0]       outOpcode,
  output logic             outBusy,
  output logic             outDone,
  output logic [1:0]       outErr,
  output logic             outDropped
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SCAN = 3'd1,
    S_EVAL = 3'd2,
    S_SEND = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  localparam logic [7:0] NUM_TGT8 = 8'(NUM_TARGETS);

  state_e state_q, state_d;

  logic [8:0]       len_q, len_d;
  logic [7:0]       acc_q, acc_d;
  logic [7:0]       op_q, op_d;
  logic [7:0]       tgt_q, tgt_d;
  logic [7:0]       plen_q, plen_d;
  logic [7:0]       k_q, k_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [TGT_W-1:0] otgt_q, otgt_d;
  logic [7:0]       oop_q, oop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;
  logic             drop_q, drop_d;

  logic       scan_last;
  logic       send_last_hs;
  logic [1:0] eval_err;
  logic [8:0] need_len;

  // SCAN walks addr_q as its byte index; the final index is N-1.
  assign scan_last    = ({1'b0, addr_q} == (len_q - 9'd1));
  assign send_last_hs = valid_q && inReady && (k_q == (plen_q - 8'd1));
  assign need_len     = {1'b0, plen_q} + 9'd4;

  always_comb begin
    eval_err = 2'd0;
    if ((len_q < 9'd4) || (len_q != need_len)) begin
      eval_err = 2'd1;
    end else if (tgt_q >= NUM_TGT8) begin
      eval_err = 2'd2;
    end else if (acc_q != 8'd0) begin
      eval_err = 2'd3;
    end
  end

  // State register
  always_ff @(posedge inCLK) begin
    if (inRST) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (inFrameDone) state_d = (inFrameLen == 9'd0) ? S_EVAL : S_SCAN;
      S_SCAN: if (scan_last) state_d = S_EVAL;
      S_EVAL: state_d = ((eval_err != 2'd0) || (plen_q == 8'd0)) ? S_FIN : S_SEND;
      S_SEND: if (send_last_hs) state_d = S_FIN;
      S_FIN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next-values
  always_comb begin
    len_d   = len_q;
    acc_d   = acc_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    plen_d  = plen_q;
    k_d     = k_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    otgt_d  = otgt_q;
    oop_d   = oop_q;
    err_d   = err_q;
    done_d  = 1'b0;
    busy_d  = (state_d != S_IDLE);
    drop_d  = inFrameDone && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (inFrameDone) begin
          len_d  = inFrameLen;
          acc_d  = 8'd0;
          op_d   = 8'd0;
          tgt_d  = 8'd0;
          plen_d = 8'd0;
          k_d    = 8'd0;
          addr_d = (inFrameLen == 9'd0) ? 8'd3 : 8'd0;
        end
      end
      S_SCAN: begin
        acc_d = acc_q ^ inByte;
        if (addr_q == 8'd0) op_d = inByte;
        if (addr_q == 8'd1) tgt_d = inByte;
        if (addr_q == 8'd2) plen_d = inByte;
        addr_d = addr_q + 8'd1;
        if (scan_last) begin
          // Point at the first payload byte so EVAL can load it directly.
          addr_d = 8'd3;
          otgt_d = tgt_d[TGT_W-1:0];
          oop_d  = op_d;
        end
      end
      S_EVAL: begin
        if (state_d == S_SEND) begin
          data_d  = inByte;
          valid_d = 1'b1;
          last_d  = (plen_q == 8'd1);
          addr_d  = 8'd4;
          k_d     = 8'd0;
        end else begin
          err_d  = eval_err;
          done_d = 1'b1;
        end
      end
      S_SEND: begin
        if (valid_q && inReady) begin
          if (send_last_hs) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            err_d   = 2'd0;
            done_d  = 1'b1;
          end else begin
            data_d = inByte;
            addr_d = addr_q + 8'd1;
            k_d    = k_q + 8'd1;
            last_d = ((k_q + 8'd2) == plen_q);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge inCLK) begin
    if (inRST) begin
      len_q   <= 9'd0;
      acc_q   <= 8'd0;
      op_q    <= 8'd0;
      tgt_q   <= 8'd0;
      plen_q  <= 8'd0;
      k_q     <= 8'd0;
      addr_q  <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      otgt_q  <= '0;
      oop_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 2'd0;
      drop_q  <= 1'b0;
    end else begin
      len_q   <= len_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      plen_q  <= plen_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      otgt_q  <= otgt_d;
      oop_q   <= oop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  assign byteAddr   = addr_q;
  assign outData    = data_q;
  assign outValid   = valid_q;
  assign outLast    = last_q;
  assign outTarget  = otgt_q;
  assign outOpcode  = oop_q;
  assign outBusy    = busy_q;
  assign outDone    = done_q;
  assign outErr     = err_q;
  assign outDropped = drop_q;

endmodule

// File: doc/host_frame_sequencer.md
# host_frame_sequencer

Sequences host transactions captured by the TDI serializer. On each completed host frame it scans the serializer byte buffer through `byteAddr`, validates the frame header, length and checksum, and only then streams the payload to one of `NUM_TARGETS` downstream FPGA consumers, such as CNN weight or config loaders, over a valid/ready handshake. It sits between the serializer buffer and the CNN datapath loaders. It runs entirely in the system clock domain.

## Interface
- `NUM_TARGETS`, 4: number of valid target IDs; legal IDs are 0..NUM_TARGETS-1.
- `TGT_W`, 2: width of `outTarget`.

Ports:
- `inCLK` in 1: system clock. All logic is on the rising edge.
- `inRST` in 1: reset, synchronous and active-high.
- `inFrameDone` in 1: one-cycle pulse; a host frame is complete in the buffer. It is already synchronized to `inCLK`.
- `inFrameLen` in 9: number of bytes received, 0..256. Valid with `inFrameDone`.
- `byteAddr` out 8: buffer read address.
- `inByte` in 8: buffer read data. It is combinational from `byteAddr` (same cycle).
- `outData` out 8: payload byte.
- `outValid` out 1: `outData` is valid.
- `inReady` in 1: downstream accepts the byte.
- `outLast` out 1: marks the final payload byte (qualified by `outValid`).
- `outTarget` out TGT_W: target ID of the current frame.
- `outOpcode` out 8: opcode of the current frame.
- `outBusy` out 1: high while a frame is being processed.
- `outDone` out 1: one-cycle pulse at the end of every accepted frame.
- `outErr` out 2: frame status. 0=ok, 1=length, 2=target, 3=checksum. Valid from `outDone` and held until the next frame.
- `outDropped` out 1: one-cycle pulse when `inFrameDone` arrives while busy.

## Operation
Frame format (byte index):
- 0: opcode.
- 1: target ID.
- 2: payload length L.
- 3..L+2: payload.
- L+3: checksum, equal to the XOR of bytes 0..L+2.

States:
- IDLE
  - `inFrameDone` latches `inFrameLen` into N.
  - Clears the XOR accumulator and the index.
  - Goes to SCAN.
- SCAN
  - Drives `byteAddr` = index, 0..N-1; samples `inByte` each cycle.
  - Captures bytes 0, 1 and 2 into opcode/target/L registers.
  - XORs every byte 0..N-1 into the accumulator, so a correct frame ends at 0.
  - After index N-1, goes to EVAL. N=0 goes straight to EVAL.
- EVAL: one cycle. Checks in priority order:
  - length error if N<4, or if N≠L+4 (9-bit compare);
  - target error if target ≥ NUM_TARGETS;
  - checksum error if the accumulator ≠ 0.
  - On any error, goes to FIN with that code.
  - If L=0, goes to FIN with code 0.
  - Otherwise drives `byteAddr`=3, loads `outData`, sets `outValid`, and goes to SEND.
- SEND
  - Payload index k runs 0..L-1; `byteAddr`=3+k+1 prefetches the next byte.
  - On `outValid && inReady`:
    - if k<L-1, loads the next byte and increments k;
    - otherwise clears `outValid` and goes to FIN.
  - With `inReady` low, `outData`, `outLast` and `outValid` hold.
  - `outLast`=1 while k=L-1.
- FIN: one cycle.
  - Pulses `outDone`, updates `outErr`, then returns to IDLE.

Other rules:
- `outTarget` and `outOpcode` update at the end of SCAN and hold until the next SCAN completes.
- No `outValid` is ever asserted for an errored frame.
- `inFrameDone` in any state other than IDLE: the frame is ignored and `outDropped` pulses. In IDLE it is always accepted.
- Reset values:
  - `byteAddr`, `outData`, `outTarget` and `outOpcode` = 0.
  - `outValid`, `outLast`, `outBusy`, `outDone` and `outDropped` = 0.
  - `outErr` = 0; state = IDLE.
- `inRST` mid-frame aborts immediately. The next cycle shows all reset values. No `outDone` is issued for the aborted frame.

## Timing
- Cycle 0: `inFrameDone` is sampled in IDLE.
- Cycles 1..N: SCAN, with `byteAddr`=0..N-1.
- Cycle N+1: EVAL.
- First `outValid` is seen at cycle N+2.
- With `inReady` held high, there is one payload byte per cycle. The last handshake is at cycle N+L+1; FIN/`outDone` follows at cycle N+L+2.
- Errored or L=0 frames: `outDone` at cycle N+2.
- `outBusy` is high from cycle 1 through the FIN cycle inclusive.
- `byteAddr` is registered; `inByte` is sampled in the same cycle it is presented.

## Test plan
- Good frame:
  - Stimulus: N=7, bytes 21 02 03 AA BB CC FD.
  - Response: `outTarget`=2, `outOpcode`=0x21.
  - AA, BB, CC are delivered on cycles 9, 10, 11; `outLast` is set on CC.
  - `outDone` at cycle 12 with `outErr`=0.
- Checksum error:
  - Stimulus: the same frame with the last byte = FE.
  - Response: `outDone` at cycle 9 with `outErr`=3; `outValid` is never high.
- Length and target errors:
  - Stimulus: N=7 with L=05.
  - Response: `outErr`=1.
  - Stimulus: 21 07 00 26 with N=4.
  - Response: `outErr`=2 (target 7 ≥ 4), which takes priority over a checksum check.
  - Stimulus: N=2.
  - Response: `outErr`=1.
- Backpressure:
  - Stimulus: the good frame with `inReady` pattern 0,1,0,0,1,1.
  - Response: `outData` is stable while stalled. The bytes are delivered exactly once, in order; `outDone` comes one cycle after the CC handshake.
- Empty payload:
  - Stimulus: 01 00 00 01 with N=4.
  - Response: `outDone` with `outErr`=0 at cycle 6; no `outValid`.
- Reset and overrun:
  - Stimulus: `inFrameDone` pulsed during SEND.
  - Response: `outDropped` pulses and the current frame completes normally.
  - Stimulus: `inRST` asserted during SEND.
  - Response: `outValid`=0 and `outBusy`=0 the next cycle, with no `outDone`. A following good frame is processed correctly.
